// File: rtl/ordenador_bolha.sv
// ordenador_bolha: sequential bubble sort of N 4-bit entries, one compare per clock.
// Loads dados_in on inicio and sorts the entries in place. The pass ends early
// when a full pass makes no exchange. fim pulses for one cycle when the sort is done.
// Optional build macro: ORDEM_DECRESCENTE_EN selects descending order.
// When it is undefined, the order is ascending.
module ordenador_bolha #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inicio,
  input  logic [4*N-1:0] dados_in,
  output logic [4*N-1:0] dados_out,
  output logic           ocupado,
  output logic           fim
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_UM  = IW'(1);
  localparam logic [IW-1:0] LIM_INI = IW'(N - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t       estado_r, estado_s;
  logic [3:0]    ent_r [N];
  logic [3:0]    ent_s [N];
  logic [IW-1:0] j_r, j_s, j1_s;
  logic [IW-1:0] limite_r, limite_s;
  logic          troca_r, troca_s;
  logic [3:0]    x_s, y_s;
  logic [2:0]    cmp_s;
  logic          maior_s, menor_s, igual_s, trocar_s;

  // 4-bit magnitude comparator: returns {maior, menor, igual} for X versus Y
  function automatic logic [2:0] comparador_4b(input logic [3:0] x, input logic [3:0] y);
    logic [2:0] r;
    r[2] = (x > y);
    r[1] = (x < y);
    r[0] = (x == y);
    return r;
  endfunction

  assign j1_s    = j_r + IDX_UM;
  assign x_s     = ent_r[j_r];
  assign y_s     = ent_r[j1_s];
  assign cmp_s   = comparador_4b(x_s, y_s);
  assign maior_s = cmp_s[2];
  assign menor_s = cmp_s[1];
  assign igual_s = cmp_s[0];

  // Exchange decision: only a strict verdict swaps, so equal entries keep their order
  always_comb begin
`ifdef ORDEM_DECRESCENTE_EN
    trocar_s = menor_s & ~(maior_s | igual_s);
`else
    trocar_s = maior_s & ~(menor_s | igual_s);
`endif
  end

  // Next-state logic: load, compare/exchange, pass bookkeeping and early exit
  always_comb begin
    estado_s = estado_r;
    j_s      = j_r;
    limite_s = limite_r;
    troca_s  = troca_r;
    ent_s    = ent_r;
    case (estado_r)
      OCIOSO: begin
        if (inicio) begin
          for (int k = 0; k < N; k++) begin
            ent_s[k] = dados_in[4*k +: 4];
          end
          j_s      = '0;
          limite_s = LIM_INI;
          troca_s  = 1'b0;
          estado_s = COMPARA;
        end else begin
          estado_s = OCIOSO;
        end
      end
      COMPARA: begin
        if (trocar_s) begin
          ent_s[j_r]  = y_s;
          ent_s[j1_s] = x_s;
        end else begin
          ent_s = ent_r;
        end
        if (j_r == limite_r - IDX_UM) begin
          if (limite_r == IDX_UM) begin
            estado_s = FIM;
          end else if (!(troca_r || trocar_s)) begin
            estado_s = FIM;
          end else begin
            limite_s = limite_r - IDX_UM;
            j_s      = '0;
            troca_s  = 1'b0;
          end
        end else begin
          j_s     = j1_s;
          troca_s = troca_r | trocar_s;
        end
      end
      FIM: begin
        estado_s = OCIOSO;
      end
      default: begin
        estado_s = OCIOSO;
      end
    endcase
  end

  // State and entry registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r <= OCIOSO;
      j_r      <= '0;
      limite_r <= LIM_INI;
      troca_r  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        ent_r[k] <= 4'd0;
      end
    end else begin
      estado_r <= estado_s;
      j_r      <= j_s;
      limite_r <= limite_s;
      troca_r  <= troca_s;
      ent_r    <= ent_s;
    end
  end

  // Output packing straight from the entry registers
  always_comb begin
    dados_out = '0;
    for (int k = 0; k < N; k++) begin
      dados_out[4*k +: 4] = ent_r[k];
    end
  end

  assign ocupado = (estado_r == COMPARA);
  assign fim     = (estado_r == FIM);

endmodule

// File: tb/tb_ordenador_bolha.sv
// Scoreboard bench for ordenador_bolha (N=4): stimulus pushes expected results,
// a negedge monitor pops and checks them on every fim pulse.
module tb_ordenador_bolha;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inicio = 1'b0;
  logic [15:0] dados_in = 16'h0000;
  logic [15:0] dados_out;
  logic        ocupado, fim;

  typedef struct {
    logic [15:0] res;
    int          ciclos;
  } esperado_t;

  esperado_t fila[$];
  int total = 0;
  int falhas = 0;
  int cnt = 0;
  logic fim_ant = 1'b0;

  ordenador_bolha #(.N(4)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .dados_in(dados_in),
    .dados_out(dados_out), .ocupado(ocupado), .fim(fim)
  );

  always #5 clk = ~clk;

  // Expected results per build: {input, sorted result, compare cycles}
`ifdef ORDEM_DECRESCENTE_EN
  localparam logic [15:0] T1_IN = 16'h9741, T1_RES = 16'h1479; localparam int T1_C = 6;
  localparam logic [15:0] T2_IN = 16'h1479, T2_RES = 16'h1479; localparam int T2_C = 3;
  localparam logic [15:0] T3_IN = 16'hF055, T3_RES = 16'h055F; localparam int T3_C = 6;
  localparam logic [15:0] T4_IN = 16'h9741, T4_RES = 16'h1479; localparam int T4_C = 6;
`else
  localparam logic [15:0] T1_IN = 16'h1479, T1_RES = 16'h9741; localparam int T1_C = 6;
  localparam logic [15:0] T2_IN = 16'h4321, T2_RES = 16'h4321; localparam int T2_C = 3;
  localparam logic [15:0] T3_IN = 16'hF055, T3_RES = 16'hF550; localparam int T3_C = 6;
  localparam logic [15:0] T4_IN = 16'h1479, T4_RES = 16'h9741; localparam int T4_C = 6;
`endif

  task automatic check(input string nome, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      falhas++;
      $display("FAIL %s: got %h, expected %h", nome, got, exp);
    end
  endtask

  // Monitor: counts busy cycles, checks overlap, pulse width and scoreboard on fim
  always @(negedge clk) begin
    esperado_t e;
    if (rst) begin
      cnt = 0;
    end else begin
      if (ocupado && fim) begin
        total++; falhas++;
        $display("FAIL overlap: ocupado and fim both high");
      end
      if (fim && fim_ant) begin
        total++; falhas++;
        $display("FAIL fim_width: fim high for more than one cycle");
      end
      if (ocupado) begin
        cnt++;
      end else if (fim) begin
        if (fila.size() == 0) begin
          total++; falhas++;
          $display("FAIL fim_unexpected: fim pulse with nothing expected, dados_out %h", dados_out);
        end else begin
          e = fila.pop_front();
          total++;
          if (dados_out !== e.res) begin
            falhas++;
            $display("FAIL result: got %h, expected %h", dados_out, e.res);
          end
          total++;
          if (cnt != e.ciclos) begin
            falhas++;
            $display("FAIL cycles: got %0d compare cycles, expected %0d", cnt, e.ciclos);
          end
        end
      end else begin
        cnt = 0;
      end
    end
    fim_ant = fim;
  end

  task automatic esperar_fim(input string nome);
    int k = 0;
    while (!fim && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!fim) begin
      total++; falhas++;
      $display("FAIL %s: timeout waiting for fim, got 0, expected 1", nome);
    end
  endtask

  task automatic ordenar(input string nome, input logic [15:0] d, input logic [15:0] r, input int c);
    esperado_t e;
    @(negedge clk);
    dados_in = d;
    inicio = 1'b1;
    e.res = r; e.ciclos = c;
    fila.push_back(e);
    @(negedge clk);
    inicio = 1'b0;
    esperar_fim(nome);
    @(negedge clk);
  endtask

  initial begin
    esperado_t e;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_dados", dados_out, 16'h0000);
    check("reset_ocupado", {15'd0, ocupado}, 16'h0000);
    check("reset_fim", {15'd0, fim}, 16'h0000);
    // rst wins over inicio on the same edge
    dados_in = 16'h1479;
    inicio = 1'b1;
    @(negedge clk);
    check("rst_prio_ocupado", {15'd0, ocupado}, 16'h0000);
    check("rst_prio_dados", dados_out, 16'h0000);
    inicio = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    ordenar("reverse", T1_IN, T1_RES, T1_C);
    ordenar("sorted", T2_IN, T2_RES, T2_C);
    ordenar("duplicates", T3_IN, T3_RES, T3_C);
    check("hold_after_fim", dados_out, T3_RES);

    // inicio held high; dados_in changes after edge 0 and must not be re-sampled
    @(negedge clk);
    dados_in = T4_IN;
    inicio = 1'b1;
    e.res = T4_RES; e.ciclos = T4_C; fila.push_back(e);
    e.res = 16'hFFFF; e.ciclos = 3; fila.push_back(e);
    @(negedge clk);
    dados_in = 16'hFFFF;
    esperar_fim("held_first");
    @(negedge clk);
    check("held_idle_ocupado", {15'd0, ocupado}, 16'h0000);
    check("held_idle_fim", {15'd0, fim}, 16'h0000);
    @(negedge clk);
    check("held_restart_ocupado", {15'd0, ocupado}, 16'h0001);
    inicio = 1'b0;
    esperar_fim("held_second");
    @(negedge clk);

    // Reset at edge 3 of a sort aborts it with no fim pulse
    dados_in = T1_IN;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_dados", dados_out, 16'h0000);
    check("abort_ocupado", {15'd0, ocupado}, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_fim", {15'd0, fim}, 16'h0000);
    end

    total++;
    if (fila.size() != 0) begin
      falhas++;
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", fila.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", total, falhas);
    $finish;
  end

endmodule

// File: doc/ordenador_bolha.md
# ordenador_bolha

- Sequential bubble-sort controller for N 4-bit entries.
- Loads a parallel vector on `inicio`, then sorts it in place with the team's 4-bit magnitude comparator (`X, Y -> maior, menor, igual`), one comparison per clock.
- Pulses `fim` when the sort is done.
- Sits between a producer that delivers packed sample sets and any consumer that needs them ordered, such as min/max or median selection.

## Interface
- `N`, default 4: number of entries. Legal range 2..16. Entry width is fixed at 4 bits.
- `clk`  input  1: single clock. All state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `inicio`  input  1: start request. Sampled only in state OCIOSO.
- `dados_in`  input  4*N: packed entries. Entry k occupies bits [4k+3:4k].
- `dados_out`  output  4*N: current contents of the internal entry registers, same packing as `dados_in`.
- `ocupado`  output  1: high while in state COMPARA.
- `fim`  output  1: one-cycle pulse, high while in state FIM.

## Operation
- State OCIOSO:
  - `inicio`=1 at an edge loads all entries from `dados_in`.
  - Same edge sets index j=0, limite=N-1, clears the swap flag, and moves to COMPARA.
  - `inicio`=0 keeps all state.
- State COMPARA, one compare per cycle:
  - The comparator sees X=entry[j], Y=entry[j+1].
  - Ascending build: if `maior`=1, the two entries are exchanged at the edge and the swap flag is set.
  - Equal values are never exchanged, so the sort is stable.
- End of pass, i.e. the edge where j = limite-1:
  - If limite==1, go to FIM.
  - If no swap happened in this pass (current compare included), go to FIM (early exit).
  - Otherwise limite decrements by 1, j returns to 0, the swap flag clears, and the state stays COMPARA.
- Otherwise j increments by 1.
- State FIM: lasts exactly one cycle, then returns to OCIOSO.
- `dados_out` keeps the sorted values until the next load or reset.
- `inicio` is ignored in COMPARA and FIM. There is no queueing, and `dados_in` is not re-sampled.
- Reset, including mid-sort:
  - State becomes OCIOSO and all entry registers become 0.
  - j=0, limite=N-1, swap flag cleared.
  - `dados_out`=0, `ocupado`=0, `fim`=0.
  - No `fim` pulse is produced for an aborted sort.
- `rst` takes priority over `inicio` on the same edge.

## Timing
- Let C be the number of compare cycles.
  - Minimum (already sorted): C = N-1.
  - Maximum: C = N(N-1)/2. For N=4, C ranges from 3 to 6.
- The edge that samples `inicio` is edge 0.
- Compare edges are edges 1..C. Each one updates `dados_out` directly, with no extra register stage.
- `ocupado`=1 from just after edge 0 until edge C.
- `fim`=1 from just after edge C until edge C+1. Its high level is observable after edge C.
- `ocupado` and `fim` are never high together.
- Back-to-back use: the earliest new `inicio` is sampled at edge C+2, i.e. the first OCIOSO cycle.
- Outputs are registered/state-decoded only. There is no combinational path from `inicio` or `dados_in` to any output.

## Configuration
- Macro: `ORDEM_DECRESCENTE_EN`.
- Undefined (default): ascending order. An exchange happens when `maior`=1, leaving entry 0 as the smallest.
- Defined: descending order. An exchange happens when `menor`=1, leaving entry 0 as the largest.
- In both builds: equal entries are never swapped, and timing and early-exit rules are identical.

## Test plan
1. N=4, entries [0..3]=9,7,4,1, pulse `inicio`:
   - exactly 6 `ocupado` cycles, then `fim` for 1 cycle;
   - `dados_out` entries = 1,4,7,9, i.e. packed 16'h9741.
2. Entries 1,2,3,4 (already sorted):
   - early exit after 3 compare cycles, `fim` high after edge 3;
   - `dados_out` unchanged = 16'h4321.
3. Entries 5,5,0,F (duplicates):
   - result 0,5,5,F, packed 16'hF550, after 6 compare cycles;
   - the two 5s are never exchanged with each other.
4. `inicio` held high through a sort of 9,7,4,1 while `dados_in` changes to all-F after edge 0:
   - result still 1,4,7,9 with a single `fim` pulse;
   - the next sort starts only at the first OCIOSO-cycle edge.
5. `rst` asserted at edge 3 of a sort of 9,7,4,1:
   - next cycle `dados_out`=0, `ocupado`=0;
   - no `fim` pulse in the following 10 cycles.
6. With `ORDEM_DECRESCENTE_EN` defined:
   - entries 1,4,7,9 give 9,7,4,1 in 6 compare cycles;
   - entries 9,7,4,1 exit after 3 compare cycles, unchanged.
